// File: rtl/dump_ctrl_if.sv
// Signal bundle between the dump controller and its command, RAM and UART neighbours.
// The slave modport is the controller's view; master is the environment's view.
interface dump_ctrl_if #(
    parameter int unsigned LOG2 = 9
);
    logic            dump;
    logic [2:0]      dump_chan;
    logic [LOG2-1:0] waddr;
    logic [7:0]      rdata;
    logic            tx_done;
    logic            ren;
    logic [LOG2-1:0] raddr;
    logic [2:0]      chan_sel;
    logic [7:0]      tx_data;
    logic            trmt;
    logic            busy;
    logic            dump_done;

    modport slave (
        input  dump, dump_chan, waddr, rdata, tx_done,
        output ren, raddr, chan_sel, tx_data, trmt, busy, dump_done
    );

    modport master (
        output dump, dump_chan, waddr, rdata, tx_done,
        input  ren, raddr, chan_sel, tx_data, trmt, busy, dump_done
    );
endinterface

// File: rtl/dump_ctrl.sv
// Streams one channel's capture RAM out over the UART, oldest sample first,
// one byte per read/latch/send/wait-for-tx_done round trip.
module dump_ctrl #(
    parameter int unsigned ENTRIES = 384,
    parameter int unsigned LOG2    = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    dump_ctrl_if.slave  bus
);
    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        WAIT_TX
    } state_t;

    state_t          state,     state_d;
    logic [LOG2-1:0] raddr_q,   raddr_d;
    logic [LOG2-1:0] cnt_q,     cnt_d;
    logic [2:0]      chan_q,    chan_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            busy_q,    busy_d;
    logic            ren_q,     ren_d;
    logic            trmt_q,    trmt_d;
    logic            done_q,    done_d;

    // State and all outputs are registered; pulse outputs are decided one cycle ahead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            raddr_q   <= '0;
            cnt_q     <= '0;
            chan_q    <= '0;
            tx_data_q <= '0;
            busy_q    <= 1'b0;
            ren_q     <= 1'b0;
            trmt_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_d;
            raddr_q   <= raddr_d;
            cnt_q     <= cnt_d;
            chan_q    <= chan_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
            ren_q     <= ren_d;
            trmt_q    <= trmt_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; ren/trmt are raised on entry to READ/SEND so they coincide with those states.
    always_comb begin
        state_d   = state;
        raddr_d   = raddr_q;
        cnt_d     = cnt_q;
        chan_d    = chan_q;
        tx_data_d = tx_data_q;
        busy_d    = busy_q;
        ren_d     = 1'b0;
        trmt_d    = 1'b0;
        done_d    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dump) begin
                    raddr_d = bus.waddr;
                    chan_d  = bus.dump_chan;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    ren_d   = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                state_d = LATCH;
            end
            LATCH: begin
                tx_data_d = bus.rdata;
                trmt_d    = 1'b1;
                state_d   = SEND;
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.tx_done) begin
                    if (cnt_q == LAST) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q + LOG2'(1);
                        // Explicit compare keeps the wrap exact when ENTRIES is not a power of two.
                        raddr_d = (raddr_q == LAST) ? '0 : raddr_q + LOG2'(1);
                        ren_d   = 1'b1;
                        state_d = READ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ren       = ren_q;
    assign bus.raddr     = raddr_q;
    assign bus.chan_sel  = chan_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.trmt      = trmt_q;
    assign bus.busy      = busy_q;
    assign bus.dump_done = done_q;
endmodule

// File: tb/tb_dump_ctrl.sv
// Randomized scoreboard bench for dump_ctrl: each dump pushes the expected
// (address, byte, channel) stream; a monitor pops one entry per trmt pulse.
module tb_dump_ctrl;
    localparam int unsigned ENTRIES = 384;
    localparam int unsigned LOG2    = 9;

    typedef struct {
        int addr;
        int data;
        int chan;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tx_rsp  = 1'b0;
    logic tx_spur = 1'b0;

    int   errors = 0;
    int   checks = 0;
    int   exp_done = 0;
    int   total_bytes = 0;
    int   fixed_delay = 0;
    bit   spur_en = 1'b0;
    exp_t exp_q[$];
    logic [7:0] mem [8][ENTRIES];

    always #5 clk = ~clk;

    dump_ctrl_if #(.LOG2(LOG2)) bus ();
    assign bus.tx_done = tx_rsp | tx_spur;

    dump_ctrl #(.ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // RAM model: read data appears for exactly the cycle after ren, junk otherwise.
    initial begin
        bit pend;
        int a;
        int c;
        pend = 1'b0;
        a = 0;
        c = 0;
        forever begin
            @(negedge clk);
            if (pend) bus.rdata = mem[c][a];
            else      bus.rdata = 8'($urandom);
            pend = rst_n && bus.ren;
            a = int'(bus.raddr);
            c = int'(bus.chan_sel);
        end
    end

    // UART model: answers each trmt with a tx_done pulse a few cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.trmt) begin
                int d;
                d = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 8));
                for (int i = 0; i < d && rst_n; i++) @(negedge clk);
                if (rst_n) begin
                    tx_rsp = 1'b1;
                    @(negedge clk);
                    tx_rsp = 1'b0;
                end
            end
        end
    end

    // Spurious tx_done while the controller is idle or reading.
    initial begin
        forever begin
            @(negedge clk);
            if (spur_en && rst_n && (bus.ren || !bus.busy)) tx_spur = 1'($urandom_range(0, 1));
            else                                            tx_spur = 1'b0;
        end
    end

    // Monitor: sample just after each rising edge, pop and compare on every trmt.
    initial begin
        exp_t e;
        logic [7:0] cur;
        bit in_flight;
        int ren_cnt;
        int ren_addr;
        cur = '0;
        in_flight = 1'b0;
        ren_cnt = 0;
        ren_addr = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                exp_q.delete();
                exp_done = 0;
                in_flight = 1'b0;
                ren_cnt = 0;
            end else begin
                if (bus.ren) begin
                    ren_cnt++;
                    ren_addr = int'(bus.raddr);
                end
                if (!bus.busy) begin
                    chk("idle_ren", 32'(bus.ren), 32'(0));
                    chk("idle_trmt", 32'(bus.trmt), 32'(0));
                end
                if (bus.trmt) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_byte", 32'(1), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("tx_data", 32'(bus.tx_data), 32'(e.data));
                        chk("raddr", 32'(bus.raddr), 32'(e.addr));
                        chk("chan_sel", 32'(bus.chan_sel), 32'(e.chan));
                        chk("ren_per_byte", 32'(ren_cnt), 32'(1));
                        chk("ren_addr", 32'(ren_addr), 32'(e.addr));
                        chk("busy_in_dump", 32'(bus.busy), 32'(1));
                        cur = 8'(e.data);
                    end
                    total_bytes++;
                    in_flight = 1'b1;
                    ren_cnt = 0;
                end else if (in_flight) begin
                    chk("tx_stable", 32'(bus.tx_data), 32'(cur));
                    if (tx_rsp) in_flight = 1'b0;
                end
                if (bus.dump_done) begin
                    if (exp_done == 0) begin
                        chk("extra_done", 32'(1), 32'(0));
                    end else begin
                        chk("done_after_last", 32'(exp_q.size()), 32'(0));
                        chk("done_busy", 32'(bus.busy), 32'(0));
                        exp_done--;
                    end
                end
            end
        end
    end

    task automatic issue_dump(input int chan, input int wa);
        exp_t e;
        @(negedge clk);
        bus.dump      = 1'b1;
        bus.dump_chan = 3'(chan);
        bus.waddr     = LOG2'(wa);
        for (int i = 0; i < int'(ENTRIES); i++) begin
            e.addr = (wa + i) % int'(ENTRIES);
            e.data = int'(mem[chan][e.addr]);
            e.chan = chan;
            exp_q.push_back(e);
        end
        exp_done++;
        @(negedge clk);
        bus.dump = 1'b0;
    endtask

    task automatic wait_done(input string name, input int start_bytes);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp_done == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk({name, "_finished"}, 32'(done), 32'(1));
        chk({name, "_bytes"}, 32'(total_bytes - start_bytes), 32'(ENTRIES));
        repeat (2) @(negedge clk);
        chk({name, "_busy_after"}, 32'(bus.busy), 32'(0));
    endtask

    task automatic run_dump(input string name, input int chan, input int wa);
        int start;
        start = total_bytes;
        issue_dump(chan, wa);
        wait_done(name, start);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ren"}, 32'(bus.ren), 32'(0));
        chk({tag, "_raddr"}, 32'(bus.raddr), 32'(0));
        chk({tag, "_chan_sel"}, 32'(bus.chan_sel), 32'(0));
        chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'(0));
        chk({tag, "_trmt"}, 32'(bus.trmt), 32'(0));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
        chk({tag, "_dump_done"}, 32'(bus.dump_done), 32'(0));
    endtask

    initial begin
        int start;
        int ch;
        bit reached;
        bus.dump      = 1'b0;
        bus.dump_chan = '0;
        bus.waddr     = '0;
        for (int c = 0; c < 8; c++)
            for (int a = 0; a < int'(ENTRIES); a++)
                mem[c][a] = 8'($urandom);

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        fixed_delay = 10;
        run_dump("base_w0_ch2", 2, 0);
        fixed_delay = 0;

        run_dump("wrap_w380", int'($urandom_range(0, 7)), 380);

        for (int a = 0; a < int'(ENTRIES); a++) mem[3][a] = 8'(a);
        run_dump("addr_data_w5", 3, 5);

        // Re-issued dumps while busy must be ignored.
        start = total_bytes;
        issue_dump(1, int'($urandom_range(0, ENTRIES - 1)));
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(50, 300)) @(negedge clk);
            bus.dump      = 1'b1;
            bus.dump_chan = 3'd4;
            bus.waddr     = LOG2'(77);
            @(negedge clk);
            bus.dump      = 1'b0;
        end
        wait_done("redump_ignored", start);
        chk("redump_chan_hold", 32'(bus.chan_sel), 32'(1));

        // Reset in the middle of byte 100 aborts the dump.
        start = total_bytes;
        issue_dump(5, int'($urandom_range(0, ENTRIES - 1)));
        reached = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (total_bytes - start >= 100) begin
                reached = 1'b1;
                break;
            end
        end
        chk("reach_byte100", 32'(reached), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_done_busy", 32'(bus.busy), 32'(0));
        run_dump("after_reset", 6, int'($urandom_range(0, ENTRIES - 1)));

        // Spurious tx_done in IDLE and READ.
        spur_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("spur_idle_busy", 32'(bus.busy), 32'(0));
        ch = int'($urandom_range(0, 7));
        run_dump("spurious", ch, int'($urandom_range(0, ENTRIES - 1)));
        repeat (20) @(negedge clk);
        spur_en = 1'b0;
        chk("spur_chan_hold", 32'(bus.chan_sel), 32'(ch));

        run_dump("final_rand", int'($urandom_range(0, 7)), int'($urandom_range(0, ENTRIES - 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dump_ctrl.md
DUMP_CTRL -- requirements
Module: dump_ctrl

Interface
REQ-001 Parameter ENTRIES, default 384, number of sample entries per channel RAM (12288 on DE-0).
REQ-002 Parameter LOG2, default 9, address width; 2^LOG2 SHALL be >= ENTRIES.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 dump  input  1  single-cycle request from cmd_cfg to dump one channel.
REQ-006 dump_chan  input  3  channel to dump; sampled with dump.
REQ-007 waddr  input  LOG2  capture write pointer, which is the oldest sample once capture is done; sampled with dump.
REQ-008 rdata  input  8  RAM read data for the selected channel, valid the cycle after ren.
REQ-009 tx_done  input  1  UART transmitter finished the current byte; single-cycle pulse.
REQ-010 ren  output  1  RAM read enable.
REQ-011 raddr  output  LOG2  RAM read address.
REQ-012 chan_sel  output  3  latched channel select to the RAM read mux.
REQ-013 tx_data  output  8  byte to the UART transmitter.
REQ-014 trmt  output  1  single-cycle pulse that starts a UART transmission.
REQ-015 busy  output  1  high from dump acceptance until dump_done.
REQ-016 dump_done  output  1  single-cycle pulse after the last byte's tx_done.

Function
REQ-017 States are IDLE, READ, LATCH, SEND, WAIT_TX.
REQ-018 IDLE with dump=1: latch raddr<=waddr, chan_sel<=dump_chan, byte count cnt<=0, busy<=1, go to READ.
REQ-019 dump SHALL be ignored in every state other than IDLE; latched raddr, chan_sel and cnt SHALL NOT change.
REQ-020 READ: ren=1 for exactly one cycle at the current raddr; go to LATCH.
REQ-021 LATCH: register tx_data<=rdata; go to SEND.
REQ-022 SEND: trmt=1 for exactly one cycle; go to WAIT_TX.
REQ-023 WAIT_TX: hold until tx_done=1; tx_data SHALL remain stable throughout.
REQ-024 On tx_done with cnt==ENTRIES-1: pulse dump_done, clear busy, go to IDLE.
REQ-025 On tx_done otherwise: cnt<=cnt+1, advance raddr, go to READ.
REQ-026 raddr advances as raddr+1, wrapping from ENTRIES-1 to 0, never reaching ENTRIES; the wrap SHALL be exact for non-power-of-2 ENTRIES.
REQ-027 Exactly ENTRIES bytes SHALL be sent per dump, oldest first: addresses waddr, waddr+1, ... mod ENTRIES.
REQ-028 tx_done received outside WAIT_TX SHALL be ignored.
REQ-029 Minimum per-byte latency from READ entry to trmt is 2 cycles; the next READ starts the cycle after tx_done.
REQ-030 ren and trmt SHALL be 0 in IDLE.
REQ-031 cnt is LOG2 bits wide; no overflow is possible because cnt <= ENTRIES-1.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, raddr=0, chan_sel=0, cnt=0, tx_data=0, ren=0, trmt=0, busy=0, dump_done=0.
REQ-033 Reset asserted mid-dump SHALL abort the dump with no dump_done pulse; after release the block SHALL accept a new dump.

Verification
REQ-034 Set ENTRIES=384 and waddr=0, then dump with chan 2, with a tx_done model 10 cycles after each trmt -> 384 trmt pulses with raddr 0..383 in order, chan_sel=2 throughout, one dump_done, busy low afterwards.
REQ-035 Dump with waddr=380 -> first raddrs are 380,381,382,383,0,1; the last raddr is 379; exactly 384 bytes are sent.
REQ-036 Preload RAM model with data = address[7:0] and dump with waddr=5 -> tx_data sequence is 0x05,0x06,...; tx_data is stable from trmt until tx_done.
REQ-037 Pulse dump again with chan 4 while busy -> chan_sel stays at the original value, the byte count is unchanged, and there is no second dump_done.
REQ-038 Assert rst_n low during byte 100 -> all outputs reach reset values immediately and there is no dump_done; a new dump then completes normally.
REQ-039 Pulse tx_done spuriously while in IDLE and READ -> no state change, and no extra bytes or skipped addresses.
